// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- memory-stage load/store sequencer
//
// Sits between the EXE/MEM pipeline register and the D-cache port. A load or
// store in MEM is checked for alignment, then issued to the D-cache with a
// request/ready handshake (and a valid handshake for load data). The pipeline
// is held via stall_MEM until the access finishes. Store data are replicated
// across byte lanes with matching write strobes. Load data are lane-shifted and
// sign/zero-extended. Misaligned accesses and D-cache response timeouts are
// reported with single-cycle pulses in the completion cycle.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   opcode_EXE_MEM        opcode of the instruction in MEM (load/store decode)
//   funct3_EXE_MEM        access size / sign
//   addr_EXE_MEM          effective byte address
//   store_data_EXE_MEM    rs2 value, unshifted
//   Dcache_req/_write     access request, 1 = store
//   Dcache_addr           word address, bits [1:0] = 0
//   Dcache_wstrb          byte write enables (0 for loads)
//   Dcache_in             lane-replicated store data
//   Dcache_ready          request accepted this cycle
//   Dcache_valid          read data valid this cycle
//   Dcache_out            raw read word
//   load_data             aligned, extended load result (held until next capture)
//   load_data_valid       pulse: load completed successfully
//   stall_MEM             hold IF..MEM pipeline registers
//   misalign              pulse: misaligned access (no D-cache request made)
//   bus_err               pulse: D-cache response timed out
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode_EXE_MEM,
    input  logic [2:0]  funct3_EXE_MEM,
    input  logic [31:0] addr_EXE_MEM,
    input  logic [31:0] store_data_EXE_MEM,
    output logic        Dcache_req,
    output logic        Dcache_write,
    output logic [31:0] Dcache_addr,
    output logic [3:0]  Dcache_wstrb,
    output logic [31:0] Dcache_in,
    input  logic        Dcache_ready,
    input  logic        Dcache_valid,
    input  logic [31:0] Dcache_out,
    output logic [31:0] load_data,
    output logic        load_data_valid,
    output logic        stall_MEM,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [6:0] OpLoad     = 7'b0000011;
    localparam logic [6:0] OpStore    = 7'b0100011;
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Latched access description, captured when leaving IDLE
    logic [29:0] r_waddr;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_write;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;

    // WAIT-cycle counter and completion bookkeeping
    logic [7:0]  r_cnt;
    logic [31:0] r_load_data;
    logic        r_ld_ok;
    logic        r_mis;
    logic        r_berr;

    // Decode of the instruction currently in MEM
    logic        w_is_load;
    logic        w_is_store;
    logic        w_mem_op;
    logic [1:0]  w_off;
    logic        w_size_byte;
    logic        w_size_half;
    logic        w_size_word;
    logic        w_misalign;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    // Load return path
    logic [31:0] w_lane;
    logic [31:0] w_load_ext;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign w_is_load  = (opcode_EXE_MEM == OpLoad);
    assign w_is_store = (opcode_EXE_MEM == OpStore);
    assign w_mem_op   = w_is_load | w_is_store;
    assign w_off      = addr_EXE_MEM[1:0];

    // funct3 100/101 are LBU/LHU for loads only; for stores they fall into the word class
    assign w_size_byte = (funct3_EXE_MEM == 3'b000) | (w_is_load & (funct3_EXE_MEM == 3'b100));
    assign w_size_half = (funct3_EXE_MEM == 3'b001) | (w_is_load & (funct3_EXE_MEM == 3'b101));
    assign w_size_word = ~w_size_byte & ~w_size_half;

    assign w_misalign = (w_size_half & w_off[0]) | (w_size_word & (w_off != 2'b00));

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = store_data_EXE_MEM;
        if (w_is_store) begin
            unique case (funct3_EXE_MEM)
                3'b000: begin
                    w_wstrb = 4'b0001 << w_off;
                    w_wdata = {4{store_data_EXE_MEM[7:0]}};
                end
                3'b001: begin
                    w_wstrb = 4'b0011 << w_off;
                    w_wdata = {2{store_data_EXE_MEM[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = store_data_EXE_MEM;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load data alignment and extension
    // -------------------------------------------------------------------------
    assign w_lane = Dcache_out >> {r_off, 3'b000};

    always_comb begin
        unique case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_ext = {24'h000000, w_lane[7:0]};
            3'b101:  w_load_ext = {16'h0000, w_lane[15:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    // Counter holds the number of completed WAIT cycles; the incremented value
    // is compared so that exactly TIMEOUT cycles are spent in WAIT.
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == TimeoutCnt);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_mem_op) begin
                    w_state_next = w_misalign ? StDone : StReq;
                end
            end
            StReq: begin
                if (Dcache_ready) begin
                    // Same-cycle ready+valid on a load skips WAIT entirely
                    w_state_next = (r_write || Dcache_valid) ? StDone : StWait;
                end
            end
            StWait: begin
                if (Dcache_valid || w_timeout) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        Dcache_req      = 1'b0;
        Dcache_write    = 1'b0;
        Dcache_wstrb    = 4'b0000;
        stall_MEM       = 1'b0;
        load_data_valid = 1'b0;
        misalign        = 1'b0;
        bus_err         = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Gated with rst so that every output drops during reset even
                // though this term is combinational on the pipeline inputs.
                stall_MEM = w_mem_op & ~rst;
            end
            StReq: begin
                Dcache_req   = 1'b1;
                Dcache_write = r_write;
                Dcache_wstrb = r_wstrb;
                stall_MEM    = 1'b1;
            end
            StWait: begin
                stall_MEM = 1'b1;
            end
            StDone: begin
                load_data_valid = r_ld_ok;
                misalign        = r_mis;
                bus_err         = r_berr;
            end
            default: begin
                stall_MEM = 1'b0;
            end
        endcase
    end

    assign Dcache_addr = {r_waddr, 2'b00};
    assign Dcache_in   = r_wdata;
    assign load_data   = r_load_data;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr     <= '0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_write     <= 1'b0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_load_data <= '0;
            r_ld_ok     <= 1'b0;
            r_mis       <= 1'b0;
            r_berr      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_mem_op) begin
                        r_mis   <= w_misalign;
                        r_ld_ok <= 1'b0;
                        r_berr  <= 1'b0;
                        // A misaligned access never reaches the D-cache, so the
                        // port registers keep their previous contents.
                        if (!w_misalign) begin
                            r_waddr  <= addr_EXE_MEM[31:2];
                            r_off    <= w_off;
                            r_funct3 <= funct3_EXE_MEM;
                            r_write  <= w_is_store;
                            r_wstrb  <= w_wstrb;
                            r_wdata  <= w_wdata;
                        end
                    end
                end
                StReq: begin
                    if (Dcache_ready) begin
                        r_cnt <= '0;
                        if (!r_write && Dcache_valid) begin
                            r_load_data <= w_load_ext;
                            r_ld_ok     <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    r_cnt <= w_cnt_inc;
                    if (Dcache_valid) begin
                        r_load_data <= w_load_ext;
                        r_ld_ok     <= 1'b1;
                    end else if (w_timeout) begin
                        r_load_data <= '0;
                        r_berr      <= 1'b1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- scoreboard bench for lsu_ctrl
//
// A driver plays the pipeline: it presents one instruction and advances only
// after a cycle with stall_MEM low. A byte-addressed memory model predicts the
// result of every access; expectations go into queues. A D-cache responder
// (word memory driven by the DUT's strobes/lanes) checks each request and
// answers with random ready/valid delays. A monitor pops expectations at every
// completion cycle and checks pulses, load_data and stall length.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int unsigned TO = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_NOP   = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode_EXE_MEM = OP_NOP;
    logic [2:0]  funct3_EXE_MEM = 3'b000;
    logic [31:0] addr_EXE_MEM = 32'h0;
    logic [31:0] store_data_EXE_MEM = 32'h0;
    logic        Dcache_req;
    logic        Dcache_write;
    logic [31:0] Dcache_addr;
    logic [3:0]  Dcache_wstrb;
    logic [31:0] Dcache_in;
    logic        Dcache_ready = 1'b0;
    logic        Dcache_valid = 1'b0;
    logic [31:0] Dcache_out = 32'h0;
    logic [31:0] load_data;
    logic        load_data_valid;
    logic        stall_MEM;
    logic        misalign;
    logic        bus_err;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode_EXE_MEM     (opcode_EXE_MEM),
        .funct3_EXE_MEM     (funct3_EXE_MEM),
        .addr_EXE_MEM       (addr_EXE_MEM),
        .store_data_EXE_MEM (store_data_EXE_MEM),
        .Dcache_req         (Dcache_req),
        .Dcache_write       (Dcache_write),
        .Dcache_addr        (Dcache_addr),
        .Dcache_wstrb       (Dcache_wstrb),
        .Dcache_in          (Dcache_in),
        .Dcache_ready       (Dcache_ready),
        .Dcache_valid       (Dcache_valid),
        .Dcache_out         (Dcache_out),
        .load_data          (load_data),
        .load_data_valid    (load_data_valid),
        .stall_MEM          (stall_MEM),
        .misalign           (misalign),
        .bus_err            (bus_err)
    );

    always #5 clk = ~clk;

    // kind: 0 store ok, 1 load ok, 2 misaligned, 3 timeout
    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [29:0] waddr;
        logic        write;
        logic [3:0]  wstrb;
        logic [31:0] din;
        bit          to;
        int          vdly;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   lat_q[$];

    logic [7:0]  ref_mem [256];  // reference: byte-addressed, low 8 address bits
    logic [31:0] mem_w [64];     // D-cache side: word-addressed, same aliasing
    logic [31:0] model_ld = 32'h0;
    bit          resp_en = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    function automatic int size_of(input bit st, input logic [2:0] f3);
        if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] kind_bits(input int kind);
        case (kind)
            1:       return 32'b100;
            2:       return 32'b010;
            3:       return 32'b001;
            default: return 32'b000;
        endcase
    endfunction

    // Present one mem op, record expectations, wait until the pipeline advances.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit to, input int vdly);
        int          sz;
        exp_t        e;
        req_t        r;
        logic [31:0] v;
        sz = size_of(st, f3);
        if ((a % sz) != 0) begin
            e.kind = 2;
            e.data = model_ld;
        end else begin
            r.waddr = a[31:2];
            r.write = st;
            r.to    = to;
            r.vdly  = vdly;
            r.wstrb = 4'b0000;
            r.din   = 32'h0;
            if (st) begin
                for (int i = 0; i < sz; i++) begin
                    r.wstrb[32'(a[1:0]) + i] = 1'b1;
                    ref_mem[8'(a + 32'(i))] = d[8*i +: 8];
                end
                r.din  = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
                e.kind = 0;
            end else if (to) begin
                model_ld = 32'h0;
                e.kind   = 3;
            end else begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
                if (sz == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
                if (sz == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
                model_ld = v;
                e.kind   = 1;
            end
            e.data = model_ld;
            req_q.push_back(r);
        end
        exp_q.push_back(e);
        opcode_EXE_MEM     = st ? OP_STORE : OP_LOAD;
        funct3_EXE_MEM     = f3;
        addr_EXE_MEM       = a;
        store_data_EXE_MEM = d;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (!stall_MEM) break;
            if (n > 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stall_bound: stall_MEM still high after %0d cycles", n);
                finish_run();
            end
        end
        @(posedge clk);
        #1;
        opcode_EXE_MEM = OP_NOP;
    endtask

    task automatic nop();
        opcode_EXE_MEM = 7'(OP_NOP | 7'($urandom_range(0, 1) << 5));
        @(negedge clk);
        check("nop_no_stall", 32'(stall_MEM), 32'h0);
        @(posedge clk);
        #1;
        opcode_EXE_MEM = OP_NOP;
    endtask

    task automatic run_random(input int count);
        int          sel;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sz;
        bit          to;
        for (int k = 0; k < count; k++) begin
            sel = $urandom_range(0, 15);
            if (sel == 0) begin
                nop();
            end else begin
                st = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                a  = $urandom;
                sz = size_of(st, f3);
                if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
                to = !st && ($urandom_range(0, 7) == 0);
                issue(st, f3, a, $urandom, to, $urandom_range(0, 3));
            end
        end
    endtask

    // D-cache responder
    initial begin : responder
        req_t r;
        int   d;
        forever begin
            @(negedge clk);
            if (resp_en && !rst && Dcache_req) begin
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_req: addr %h, no request expected", Dcache_addr);
                    Dcache_ready = 1'b1;
                    @(negedge clk);
                    Dcache_ready = 1'b0;
                end else begin
                    r = req_q.pop_front();
                    check("req_addr", Dcache_addr, {r.waddr, 2'b00});
                    check("req_write", 32'(Dcache_write), 32'(r.write));
                    check("req_wstrb", 32'(Dcache_wstrb), 32'(r.wstrb));
                    if (r.write) check("req_din", Dcache_in, r.din);
                    d = $urandom_range(0, 2);
                    repeat (d) begin
                        @(negedge clk);
                        check("req_hold", {Dcache_req, Dcache_addr[31:1]}, {1'b1, r.waddr, 1'b0});
                    end
                    Dcache_ready = 1'b1;
                    if (r.write) begin
                        for (int i = 0; i < 4; i++) begin
                            if (Dcache_wstrb[i]) mem_w[r.waddr[5:0]][8*i +: 8] = Dcache_in[8*i +: 8];
                        end
                        // valid alongside a store acceptance must be ignored
                        Dcache_valid = 1'($urandom_range(0, 1));
                        Dcache_out   = $urandom;
                        lat_q.push_back(d + 2);
                        @(negedge clk);
                        Dcache_ready = 1'b0;
                        Dcache_valid = 1'b0;
                    end else if (r.to) begin
                        lat_q.push_back(d + 2 + int'(TO));
                        @(negedge clk);
                        Dcache_ready = 1'b0;
                    end else if (r.vdly == 0) begin
                        Dcache_valid = 1'b1;
                        Dcache_out   = mem_w[r.waddr[5:0]];
                        lat_q.push_back(d + 2);
                        @(negedge clk);
                        Dcache_ready = 1'b0;
                        Dcache_valid = 1'b0;
                        Dcache_out   = $urandom;
                    end else begin
                        Dcache_out = $urandom;
                        lat_q.push_back(d + 2 + r.vdly);
                        @(negedge clk);
                        Dcache_ready = 1'b0;
                        repeat (r.vdly - 1) @(negedge clk);
                        Dcache_valid = 1'b1;
                        Dcache_out   = mem_w[r.waddr[5:0]];
                        @(negedge clk);
                        Dcache_valid = 1'b0;
                        Dcache_out   = $urandom;
                    end
                end
            end
        end
    end

    // Monitor: a 1->0 edge of stall_MEM marks the completion cycle.
    initial begin : monitor
        exp_t e;
        int   run;
        logic prev;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (prev && !stall_MEM) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: completion with nothing outstanding");
                    end else begin
                        e = exp_q.pop_front();
                        check("done_flags", {29'h0, load_data_valid, misalign, bus_err},
                              kind_bits(e.kind));
                        check("load_data", load_data, e.data);
                        if (e.kind == 2) begin
                            check("misalign_stall", 32'(run), 32'd1);
                        end else if (lat_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL latency: got completion, expected none yet");
                        end else begin
                            check("latency", 32'(run), 32'(lat_q.pop_front()));
                        end
                    end
                end else begin
                    check("no_pulse", {29'h0, load_data_valid, misalign, bus_err}, 32'h0);
                end
                run  = stall_MEM ? run + 1 : 0;
                prev = stall_MEM;
            end
        end
    end

    initial begin : main
        for (int w = 0; w < 64; w++) begin
            mem_w[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem_w[w][8*b +: 8];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {24'h0, Dcache_req, Dcache_write, Dcache_wstrb, stall_MEM,
              load_data_valid}, 32'h0);
        check("reset_load_data", load_data, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Stores: SW, SB at lane 3, SH at upper half
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 0);
        issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1'b0, 0);
        issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1'b0, 0);
        // Load decode against 0x80FF7F01
        issue(1'b1, 3'b010, 32'h0000_0200, 32'h80FF_7F01, 1'b0, 0);
        issue(1'b0, 3'b000, 32'h0000_0203, 32'h0, 1'b0, 1);
        issue(1'b0, 3'b100, 32'h0000_0203, 32'h0, 1'b0, 0);
        issue(1'b0, 3'b001, 32'h0000_0202, 32'h0, 1'b0, 2);
        issue(1'b0, 3'b101, 32'h0000_0200, 32'h0, 1'b0, 3);
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b0, 1);
        // Misaligned
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0, 1'b0, 0);
        issue(1'b0, 3'b001, 32'h0000_0101, 32'h0, 1'b0, 0);
        // Timeout
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b1, 0);
        nop();

        run_random(300);

        // Asynchronous reset while a SW sits in REQ
        resp_en            = 1'b0;
        opcode_EXE_MEM     = OP_STORE;
        funct3_EXE_MEM     = 3'b010;
        addr_EXE_MEM       = 32'h0000_0100;
        store_data_EXE_MEM = 32'h1357_9BDF;
        @(negedge clk);
        check("rst_test_idle_stall", 32'(stall_MEM), 32'h1);
        @(negedge clk);
        check("rst_test_in_req", 32'(Dcache_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", {24'h0, Dcache_req, Dcache_write, Dcache_wstrb, stall_MEM,
              load_data_valid}, 32'h0);
        check("async_rst_flags", {30'h0, misalign, bus_err}, 32'h0);
        check("async_rst_addr", Dcache_addr, 32'h0);
        check("async_rst_din", Dcache_in, 32'h0);
        check("async_rst_load_data", load_data, 32'h0);
        model_ld       = 32'h0;
        opcode_EXE_MEM = OP_NOP;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {30'h0, Dcache_req, stall_MEM}, 32'h0);
        resp_en = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b0, 1);

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("req_q_drained", 32'(req_q.size()), 32'h0);
        check("lat_q_drained", 32'(lat_q.size()), 32'h0);
        finish_run();
    end

endmodule
